sram_stream_reader: RTL and testbench

Upstream Wishbone master for the SPI SRAM controller. Given a base address and a byte count, it fetches the bytes with single-byte Wishbone reads, buffers them in a small FIFO, and presents them to the edit-distance engine as a valid/ready byte stream. Requests are issued only while the FIFO has room, so a stalled consumer never loses data and never causes a bus error.

---
 rtl/sram_stream_reader_if.sv | 24 ++
 rtl/sram_stream_reader.sv | 170 +++++++++++++++++
 tb/tb_sram_stream_reader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_stream_reader_if.sv
// Wishbone classic read port between the stream reader (master) and the SPI SRAM controller (slave).
interface sram_stream_reader_if;
    logic        cyc_o;
    logic        stb_o;
    logic [23:0] adr_o;
    logic        we_o;
    logic [7:0]  dat_o;
    logic [2:0]  cti_o;
    logic [1:0]  bte_o;
    logic        ack_i;
    logic        err_i;
    logic        rty_i;
    logic [7:0]  dat_i;

    modport master (
        output cyc_o, stb_o, adr_o, we_o, dat_o, cti_o, bte_o,
        input  ack_i, err_i, rty_i, dat_i
    );

    modport slave (
        input  cyc_o, stb_o, adr_o, we_o, dat_o, cti_o, bte_o,
        output ack_i, err_i, rty_i, dat_i
    );
endinterface

// File: rtl/sram_stream_reader.sv
// Fetches len_i bytes from SPI SRAM with single-byte Wishbone reads and streams them out through a small FIFO.
// Optional macro SRAM_STREAM_ERR_EN enables retry/error termination handling and the sticky err_o flag.
module sram_stream_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [23:0]          base_adr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [7:0]           data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    sram_stream_reader_if.master wb
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, REQ, GAP, HOLD, DRAIN} state_t;

    state_t               state_reg, state_next;
    logic [23:0]          adr_reg, adr_next;
    logic [LEN_WIDTH-1:0] remaining_reg, remaining_next;
    logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]          count_reg;
    logic                 done_reg, done_next;
    logic                 err_reg, err_next;
    logic                 push, pop, flush;
    logic [7:0]           mem [FIFO_DEPTH];

    assign pop     = valid_o && ready_i;
    assign valid_o = (count_reg != '0);
    // Gate the head byte so data_o is defined (zero) whenever the FIFO is empty.
    assign data_o  = valid_o ? mem[rd_ptr_reg] : 8'h00;
    assign busy_o  = (state_reg != IDLE);
    assign done_o  = done_reg;

    assign wb.cyc_o = (state_reg == REQ);
    assign wb.stb_o = (state_reg == REQ);
    assign wb.adr_o = adr_reg;
    assign wb.we_o  = 1'b0;
    assign wb.dat_o = 8'h00;
    assign wb.cti_o = 3'b000;
    assign wb.bte_o = 2'b00;

`ifdef SRAM_STREAM_ERR_EN
    assign err_o = err_reg;
`else
    logic unused_err;
    assign err_o      = 1'b0;
    assign unused_err = ^{err_reg, wb.err_i, wb.rty_i};
`endif

    always_comb begin
        state_next     = state_reg;
        adr_next       = adr_reg;
        remaining_next = remaining_reg;
        done_next      = 1'b0;
        err_next       = err_reg;
        push           = 1'b0;
        flush          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    err_next = 1'b0;
                    if (len_i == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next     = REQ;
                        adr_next       = base_adr_i;
                        remaining_next = len_i;
                        flush          = 1'b1;
                    end
                end
            end
            REQ: begin
                if (wb.ack_i) begin
                    push           = 1'b1;
                    adr_next       = adr_reg + 24'd1;
                    remaining_next = remaining_reg - LEN_WIDTH'(1);
                    state_next     = GAP;
                end
`ifdef SRAM_STREAM_ERR_EN
                else if (wb.err_i) begin
                    err_next   = 1'b1;
                    flush      = 1'b1;
                    state_next = IDLE;
                end else if (wb.rty_i) begin
                    state_next = GAP;
                end
`endif
            end
            GAP: begin
                // The final byte may already be popped during the gap cycle, so finish here too.
                if (remaining_reg == '0) begin
                    if (pop && count_reg == (AW+1)'(1)) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (count_reg < DEPTH_C) begin
                    state_next = REQ;
                end else begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (count_reg < DEPTH_C) state_next = REQ;
            end
            DRAIN: begin
                if (pop && count_reg == (AW+1)'(1)) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort overrides everything, including a start or termination in the same cycle.
        if (abort_i) begin
            state_next = IDLE;
            flush      = 1'b1;
            push       = 1'b0;
            done_next  = 1'b0;
            err_next   = err_reg;
            adr_next   = adr_reg;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            adr_reg       <= '0;
            remaining_reg <= '0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            adr_reg       <= adr_next;
            remaining_reg <= remaining_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
                case ({push, pop})
                    2'b10:   count_reg <= count_reg + (AW+1)'(1);
                    2'b01:   count_reg <= count_reg - (AW+1)'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_reg] <= wb.dat_i;
    end
endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader: table-driven fetches plus hand sequences for backpressure, abort, errors and reset.
module tb_sram_stream_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, ready;
    logic [23:0] base_adr;
    logic [15:0] len;
    logic        busy, done, err, valid;
    logic [7:0]  data;

    sram_stream_reader_if wb ();

    sram_stream_reader #(.FIFO_DEPTH(4), .LEN_WIDTH(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .base_adr_i(base_adr), .len_i(len), .busy_o(busy), .done_o(done),
        .err_o(err), .data_o(data), .valid_o(valid), .ready_i(ready), .wb(wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] base;
        int          len;
        int          ack_delay;
        int          ready_mode;
        int          exp_txn;
        logic [23:0] exp_last_adr;
    } vec_t;

    int checks = 0, failures = 0;
    int ack_delay = 1, wait_cnt = 0, txn_cnt = 0, done_cnt = 0, ready_mode = 0;
    int abort_on_txn = 0, rty_on_txn = 0, err_on_txn = 0, rty_cnt = 0;
    logic term_prev = 1'b0, done_after_pop = 1'b1, pop_emptied = 1'b0, prev_pop_emptied = 1'b0;
    logic [23:0] last_ack_adr = '0;
    logic [7:0]  exp_q[$];
    logic [23:0] exp_adr_q[$];
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sram_byte(input logic [23:0] a);
        case (a)
            24'h000010: return 8'hA1;
            24'h000011: return 8'hB2;
            24'h000012: return 8'hC3;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
        endcase
    endfunction

    // SRAM slave model: terminates each request after ack_delay cycles, checks addresses in order.
    always @(posedge clk) begin
        #1;
        if (term_prev) chk("cyc_low_after_term", 32'(wb.cyc_o), 32'd0);
        term_prev = 1'b0;
        wb.ack_i = 1'b0; wb.rty_i = 1'b0; wb.err_i = 1'b0;
        if (rst_n && wb.cyc_o && wb.stb_o) begin
            wait_cnt++;
            if (wait_cnt >= ack_delay) begin
                wait_cnt  = 0;
                term_prev = 1'b1;
                if (exp_adr_q.size() == 0) chk("adr_unexpected", 32'(wb.adr_o), 32'hFFFF_FFFF);
                else chk("adr", 32'(wb.adr_o), 32'(exp_adr_q[0]));
                if (rty_on_txn == txn_cnt + 1 && rty_cnt == 0) begin
                    wb.rty_i = 1'b1;
                    rty_cnt++;
                    $display("txn adr=%06h retry", wb.adr_o);
                end else begin
                    if (exp_adr_q.size() != 0) void'(exp_adr_q.pop_front());
                    txn_cnt++;
                    last_ack_adr = wb.adr_o;
                    if (err_on_txn == txn_cnt) begin
                        wb.err_i = 1'b1;
                        $display("txn adr=%06h error", wb.adr_o);
                    end else begin
                        wb.ack_i = 1'b1;
                        wb.dat_i = sram_byte(wb.adr_o);
                        $display("txn adr=%06h dat=%02h", wb.adr_o, wb.dat_i);
                    end
                    if (abort_on_txn == txn_cnt) abort = 1'b1;
                end
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0)      ready = 1'b1;
        else if (ready_mode == 1) ready = 1'($urandom_range(0, 1));
        else                      ready = 1'b0;
    end

    // Stream scoreboard and done-pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            pop_emptied = 1'b0;
            if (valid && ready) begin
                if (exp_q.size() == 0) chk("stream_extra", 32'(data), 32'hFFFF_FFFF);
                else chk("stream", 32'(data), 32'(exp_q.pop_front()));
                pop_emptied = (exp_q.size() == 0);
            end
            if (done) begin
                done_cnt++;
                if (done_after_pop) chk("done_after_last_pop", 32'(prev_pop_emptied), 32'd1);
            end
            prev_pop_emptied = pop_emptied;
        end
    end

    task automatic load_expect(input logic [23:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(sram_byte(b + 24'(i)));
            exp_adr_q.push_back(b + 24'(i));
        end
    endtask

    task automatic issue_start(input logic [23:0] b, input int n);
        @(posedge clk); #1;
        base_adr = b; len = 16'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 4000 && done_cnt == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk(name, 32'(done_cnt), 32'd1);
    endtask

    task automatic run_fetch(input vec_t v);
        ack_delay = v.ack_delay; ready_mode = v.ready_mode;
        txn_cnt = 0; done_cnt = 0;
        load_expect(v.base, v.len);
        issue_start(v.base, v.len);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("cyc_after_start", 32'(wb.cyc_o), 32'd1);
        wait_done("fetch_done_once");
        chk("fetch_txn_count", 32'(txn_cnt), 32'(v.exp_txn));
        chk("fetch_last_adr", 32'(last_ack_adr), 32'(v.exp_last_adr));
        chk("fetch_stream_drained", 32'(exp_q.size()), 32'd0);
        chk("fetch_idle", 32'({busy, valid}), 32'd0);
        $display("fetch base=%06h len=%0d txns=%0d done=%0d", v.base, v.len, txn_cnt, done_cnt);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_adr = '0; len = '0; ready = 1'b0;
        wb.ack_i = 1'b0; wb.err_i = 1'b0; wb.rty_i = 1'b0; wb.dat_i = 8'h00;
        vecs[0] = '{24'h000010, 3, 80, 0, 3, 24'h000012};
        vecs[1] = '{24'h000123, 6, 2, 1, 6, 24'h000128};
        vecs[2] = '{24'hFFFFFF, 2, 1, 0, 2, 24'h000000};
        vecs[3] = '{24'h7FFFFE, 9, 4, 1, 9, 24'h800006};

        repeat (3) @(negedge clk);
        chk("reset_bus", 32'({wb.cyc_o, wb.stb_o}), 32'd0);
        chk("reset_adr", 32'(wb.adr_o), 32'd0);
        chk("reset_status", 32'({busy, done, err, valid}), 32'd0);
        chk("reset_data", 32'(data), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_fetch(vecs[i]);

        // Zero length: done next cycle, no bus activity.
        done_after_pop = 1'b0; txn_cnt = 0; done_cnt = 0;
        issue_start(24'h000050, 0);
        chk("zero_len_done", 32'(done), 32'd1);
        chk("zero_len_cyc", 32'(wb.cyc_o), 32'd0);
        chk("zero_len_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("zero_len_done_single", 32'(done), 32'd0);
        repeat (5) @(negedge clk);
        chk("zero_len_no_txn", 32'(txn_cnt), 32'd0);
        done_after_pop = 1'b1;

        // Backpressure: FIFO fills after four reads, then the bus stays idle.
        ack_delay = 1; ready_mode = 2; txn_cnt = 0; done_cnt = 0;
        load_expect(24'h000200, 8);
        issue_start(24'h000200, 8);
        repeat (60) @(negedge clk);
        chk("bp_txn_count", 32'(txn_cnt), 32'd4);
        chk("bp_bus_idle", 32'(wb.cyc_o), 32'd0);
        chk("bp_busy_valid", 32'({busy, valid}), 32'd3);
        ready_mode = 0;
        wait_done("bp_done_once");
        chk("bp_txn_total", 32'(txn_cnt), 32'd8);
        chk("bp_stream_drained", 32'(exp_q.size()), 32'd0);

        // Abort coinciding with the second ack.
        ack_delay = 2; ready_mode = 2; txn_cnt = 0; done_cnt = 0; abort_on_txn = 2;
        load_expect(24'h000300, 4);
        issue_start(24'h000300, 4);
        for (int k = 0; k < 200 && !abort; k++) @(negedge clk);
        chk("abort_reached", 32'(abort), 32'd1);
        @(posedge clk); #1;
        abort = 1'b0; abort_on_txn = 0;
        chk("abort_cyc", 32'(wb.cyc_o), 32'd0);
        chk("abort_valid_busy", 32'({valid, busy}), 32'd0);
        exp_q.delete(); exp_adr_q.delete();
        repeat (6) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_txn_count", 32'(txn_cnt), 32'd2);
        run_fetch(vecs[0]);

`ifdef SRAM_STREAM_ERR_EN
        rty_on_txn = 1; rty_cnt = 0;
        run_fetch('{24'h000040, 3, 1, 0, 3, 24'h000042});
        chk("rty_seen", 32'(rty_cnt), 32'd1);
        rty_on_txn = 0;

        ack_delay = 1; ready_mode = 2; txn_cnt = 0; done_cnt = 0; err_on_txn = 2;
        load_expect(24'h000400, 4);
        issue_start(24'h000400, 4);
        for (int k = 0; k < 200 && !err; k++) @(negedge clk);
        chk("err_set", 32'(err), 32'd1);
        chk("err_idle", 32'({busy, valid, wb.cyc_o}), 32'd0);
        err_on_txn = 0;
        exp_q.delete(); exp_adr_q.delete();
        repeat (4) @(negedge clk);
        chk("err_no_done", 32'(done_cnt), 32'd0);
        run_fetch(vecs[2]);
        chk("err_cleared_by_start", 32'(err), 32'd0);
`endif

        // Asynchronous reset in the middle of a request.
        ack_delay = 10; ready_mode = 2; txn_cnt = 0; done_cnt = 0;
        load_expect(24'h000500, 4);
        issue_start(24'h000500, 4);
        for (int k = 0; k < 50 && !wb.cyc_o; k++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bus", 32'({wb.cyc_o, wb.stb_o}), 32'd0);
        chk("arst_adr", 32'(wb.adr_o), 32'd0);
        chk("arst_status", 32'({busy, done, err, valid}), 32'd0);
        chk("arst_data", 32'(data), 32'd0);
        exp_q.delete(); exp_adr_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_fetch(vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
